nn_stream_fifo: RTL and testbench
=================================

Name: nn_stream_fifo

Overview:
- Parametrised synchronous single-clock FIFO for buffering activation and weight words between NN accelerator stages.
- Generalises the existing 2-entry buffer:
  - configurable width and depth;
  - correct occupancy counting with full/empty and programmable almost-full/almost-empty thresholds;
  - selectable read mode: first-word fall-through or registered.
- Sits between DMA/load units and PE-array input staging.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries; legal range 1..10.
- AFULL_LVL, 12, almost_full asserted when count >= AFULL_LVL; legal range 1..DEPTH.
- AEMPTY_LVL, 2, almost_empty asserted when count <= AEMPTY_LVL; legal range 0..DEPTH-1.
- FWFT, 1:
  - 1 = first-word fall-through: data_out shows the head word whenever !empty.
  - 0 = registered read: data_out is valid one cycle after an accepted read.

Ports:
- sys_clk  in  1  clock, rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request / pop.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LVL.
- almost_empty  out  1  count <= AEMPTY_LVL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, sys_rst_n low):
  - wr_ptr = 0, rd_ptr = 0, count = 0;
  - data_out register = 0, so FWFT=1 also shows 0 while empty;
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents; the next accepted write lands at entry 0.
- Accepted operations:
  - wr_acc = wr_en & !full.
  - rd_acc = rd_en & !empty.
- Write:
  - On wr_acc, mem[wr_ptr] <= data_in and wr_ptr <= wr_ptr+1.
  - Pointer wraps modulo DEPTH naturally at ADDR_WIDTH bits.
- Read:
  - On rd_acc, rd_ptr <= rd_ptr+1, with the same wrap rule.
- Count update:
  - wr_acc & rd_acc: count unchanged.
  - wr_acc only: count+1.
  - rd_acc only: count-1.
  - count width ADDR_WIDTH+1 so DEPTH is representable; count never leaves 0..DEPTH.
- Flags are combinational decodes of registered count; no extra latency.
- Full boundary:
  - wr_en while full is ignored: no pointer, count or memory change, even if rd_acc occurs the same cycle.
  - Simultaneous wr_en & rd_en when full: only the read is accepted; count becomes DEPTH-1.
- Empty boundary:
  - rd_en while empty is ignored.
  - Simultaneous wr_en & rd_en when empty: only the write is accepted; count becomes 1.
- FWFT=1:
  - data_out = mem[rd_ptr], combinational from the array, when !empty.
  - When empty, data_out holds its last value.
  - Write-to-visible latency: 1 cycle (word written at edge N is visible after edge N).
- FWFT=0:
  - On rd_acc, data_out <= mem[rd_ptr] at that edge.
  - Otherwise data_out holds its value.
  - Read latency: 1 cycle.
- Write-then-read of the same entry is always ordered: memory write and pointer compare both use registered state.

Optional Feature:
- Macro: NN_FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds outputs overflow (1) and underflow (1), plus input err_clr (1).
  - overflow sets sticky on wr_en & full; underflow sets sticky on rd_en & empty.
  - Both clear on err_clr, or on reset (reset value 0).
  - If set and clear occur in the same cycle, set wins.
- Not defined: ports absent; illegal requests are silently ignored as above.

Decomposition:
- Package nn_fifo_pkg holds:
  - function clog2;
  - localparam-style helper constants (default widths);
  - typedef fifo_status_t packing {full, empty, almost_full, almost_empty}.
- Sub-module nn_fifo_mem:
  - simple dual-port register array with write port (we, waddr, wdata) and async read port (raddr, rdata), parameterised DATA_WIDTH/ADDR_WIDTH.
  - Top holds pointers, count, flags and the read-mode output logic.

Test Plan (DEPTH=16 unless stated):
- Reset then idle: after reset release, empty=1, almost_empty=1, full=0, count=0, data_out=0; rd_en pulse leaves count=0 and pointers unchanged.
- Fill/drain ordering: write 0x00..0x0F on 16 consecutive cycles → full=1, count=16, almost_full from count=12; then read 16 words → data_out sequence 0x00..0x0F in order, empty=1 at end. Run with FWFT=1 (data visible before rd_en) and FWFT=0 (data one cycle after rd_en).
- Full boundary: at count=16, wr_en with data 0xDEAD → ignored, subsequent reads return no 0xDEAD. Simultaneous wr/rd at full → count=15, head popped, write dropped.
- Empty boundary: at count=0, simultaneous wr_en(0x55)/rd_en → count=1, next read returns 0x55.
- Wrap-around: 40 cycles of concurrent write and read at steady count=3 → count stays 3, pointers wrap past 15→0, data order preserved.
- Reset mid-stream and error flags: assert sys_rst_n low asynchronously at count=7 → all flags and count return to reset values immediately. With NN_FIFO_ERR_FLAGS_EN, overflow/underflow set on illegal requests, hold, and clear on err_clr.

Source files
------------

// File: rtl/nn_fifo_pkg.sv
// Shared constants, status bundle and helpers for the NN stream FIFO.
package nn_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/nn_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read. Not reset.
module nn_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  sys_clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge sys_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nn_stream_fifo.sv
// Parametrised single-clock FIFO with occupancy flags and FWFT/registered read.
// Optional sticky overflow/underflow flags with err_clr under NN_FIFO_ERR_FLAGS_EN.
module nn_stream_fifo
  import nn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef NN_FIFO_ERR_FLAGS_EN
  ,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int                DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_LVL);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rdata, dout_q;
  logic                  wr_acc, rd_acc;
  fifo_status_t          status;

  // Flags decode straight from the registered count.
  always_comb begin
    status.full         = (count == DEPTH_CNT);
    status.empty        = (count == '0);
    status.almost_full  = (count >= AFULL_CNT);
    status.almost_empty = (count <= AEMPTY_CNT);
  end

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  assign wr_acc = wr_en & ~status.full;
  assign rd_acc = rd_en & ~status.empty;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  nn_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .sys_clk (sys_clk),
    .we      (wr_acc),
    .waddr   (wr_ptr),
    .wdata   (data_in),
    .raddr   (rd_ptr),
    .rdata   (rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Shadow the head while non-empty so the last word stays visible once drained.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)         dout_q <= '0;
        else if (!status.empty) dout_q <= rdata;
      end
      assign data_out = status.empty ? dout_q : rdata;
    end else begin : g_reg
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  dout_q <= '0;
        else if (rd_acc) dout_q <= rdata;
      end
      assign data_out = dout_q;
    end
  endgenerate

`ifdef NN_FIFO_ERR_FLAGS_EN
  // Set has priority over err_clr in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & status.full) overflow <= 1'b1;
      else if (err_clr)        overflow <= 1'b0;
      if (rd_en & status.empty) underflow <= 1'b1;
      else if (err_clr)         underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_nn_stream_fifo.sv
// Directed scoreboard bench: one FWFT and one registered-read instance share stimulus.
module tb_nn_stream_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int AEL   = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] dout_f, dout_r;
  logic          full_f, empty_f, af_f, ae_f;
  logic          full_r, empty_r, af_r, ae_r;
  logic [AW:0]   count_f, count_r;
`ifdef NN_FIFO_ERR_FLAGS_EN
  logic          ovf_f, udf_f, ovf_r, udf_r;
`endif

  always #5 sys_clk = ~sys_clk;

  nn_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL), .FWFT(1)) u_fwft (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .wr_en (wr_en), .data_in (data_in), .rd_en (rd_en),
    .data_out (dout_f), .full (full_f), .empty (empty_f), .almost_full (af_f), .almost_empty (ae_f),
    .count (count_f)
`ifdef NN_FIFO_ERR_FLAGS_EN
    , .err_clr (err_clr), .overflow (ovf_f), .underflow (udf_f)
`endif
  );

  nn_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL), .FWFT(0)) u_reg (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .wr_en (wr_en), .data_in (data_in), .rd_en (rd_en),
    .data_out (dout_r), .full (full_r), .empty (empty_r), .almost_full (af_r), .almost_empty (ae_r),
    .count (count_r)
`ifdef NN_FIFO_ERR_FLAGS_EN
    , .err_clr (err_clr), .overflow (ovf_r), .underflow (udf_r)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] q[$];
  int          mcount = 0;
  logic [31:0] last_f = '0;
  logic [31:0] last_r = '0;
  logic        ovf_m = 1'b0;
  logic        udf_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mcount = 0;
    last_f = '0;
    last_r = '0;
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] exp_f;
    exp_f = (q.size() != 0) ? q[0] : last_f;
    last_f = exp_f;
    chk({tag, ".count_f"}, 32'(count_f), 32'(mcount));
    chk({tag, ".count_r"}, 32'(count_r), 32'(mcount));
    chk({tag, ".full"},   {30'b0, full_f,  full_r},  {30'b0, {2{mcount == DEPTH}}});
    chk({tag, ".empty"},  {30'b0, empty_f, empty_r}, {30'b0, {2{mcount == 0}}});
    chk({tag, ".afull"},  {30'b0, af_f,    af_r},    {30'b0, {2{mcount >= AFL}}});
    chk({tag, ".aempty"}, {30'b0, ae_f,    ae_r},    {30'b0, {2{mcount <= AEL}}});
    chk({tag, ".dout_fwft"}, dout_f, exp_f);
    chk({tag, ".dout_reg"},  dout_r, last_r);
`ifdef NN_FIFO_ERR_FLAGS_EN
    chk({tag, ".ovf"}, {30'b0, ovf_f, ovf_r}, {30'b0, {2{ovf_m}}});
    chk({tag, ".udf"}, {30'b0, udf_f, udf_r}, {30'b0, {2{udf_m}}});
`endif
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, then check.
  task automatic step(input string tag, input logic w, input logic [31:0] d, input logic r);
    logic wa, ra, ovf_n, udf_n;
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    wa    = w && (mcount < DEPTH);
    ra    = r && (mcount > 0);
    ovf_n = (w && mcount == DEPTH) ? 1'b1 : (err_clr ? 1'b0 : ovf_m);
    udf_n = (r && mcount == 0)     ? 1'b1 : (err_clr ? 1'b0 : udf_m);
    @(posedge sys_clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (ra) last_r = q.pop_front();
    if (wa) q.push_back(d);
    mcount = mcount + int'(wa) - int'(ra);
    ovf_m = ovf_n;
    udf_m = udf_n;
    check_state(tag);
  endtask

  initial begin
    model_reset();
    #12 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    check_state("reset");

    step("rd_empty", 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 32'(i), 1'b0);
    step("wr_full", 1'b1, 32'hDEAD, 1'b0);
    step("wr_rd_full", 1'b1, 32'hDEAD, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) step("drain", 1'b0, 32'h0, 1'b1);

    step("rd_empty2", 1'b0, 32'h0, 1'b1);
    err_clr = 1'b1;
    step("err_clr", 1'b0, 32'h0, 1'b0);
    err_clr = 1'b0;
    step("wr_rd_empty", 1'b1, 32'h55, 1'b1);
    step("rd_55", 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 3; i++) step("prefill", 1'b1, 32'h200 + 32'(i), 1'b0);
    for (int i = 0; i < 40; i++) step("wrap", 1'b1, 32'h100 + 32'(i), 1'b1);
    for (int i = 0; i < 3; i++) step("wrap_drain", 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 7; i++) step("fill7", 1'b1, 32'hA00 + 32'(i), 1'b0);
    #3 sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    #2 sys_rst_n = 1'b1;
    step("post_rst_wr", 1'b1, 32'hA5, 1'b0);
    step("post_rst_rd", 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 32'h300 + 32'(i), 1'b0);
    err_clr = 1'b1;
    step("set_wins", 1'b1, 32'hBEEF, 1'b0);
    step("clr", 1'b0, 32'h0, 1'b0);
    err_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
